// File: rtl/ram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ram_rd_arbiter
//   Shares the single read port of one ram (registered output, 1-cycle read
//   latency) between NUM_REQ requesters. Round-robin arbitration between
//   bursts, with the grant locked to one requester until it completes a beat
//   marked last. One read can be issued every cycle, including when the grant
//   moves from one requester to another.
//
// Ports
//   clk            single clock, all logic on posedge
//   reset_n        asynchronous active-low reset
//   req_valid      per-requester read request
//   req_addr       requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_last       beat is the last of its burst (tie 1 for single reads)
//   req_ready      one-hot grant; a beat is accepted when valid & ready
//   rsp_valid      one-hot owner of the data on rsp_data
//   rsp_data       read data, straight from the ram
//   ram_read_req   ram read strobe
//   ram_read_addr  ram read address
//   ram_read_data  ram read data
// ---------------------------------------------------------------------------
module ram_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_read_req,
  output logic [ADDR_WIDTH-1:0]         ram_read_addr,
  input  logic [DATA_WIDTH-1:0]         ram_read_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic             grant_any;

  // Grant selection. Held at zero while reset is asserted so that nothing
  // reaches the ram during reset. In IDLE the search starts at the
  // round-robin pointer and wraps; in LOCKED only the owner may be served,
  // and a missing owner request simply produces a bubble.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (reset_n) begin
      if (state == LOCKED) begin
        if (req_valid[owner]) begin
          grant_any = 1'b1;
          grant_idx = owner;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
          if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
  end

  // Ram request is driven in the same cycle as the handshake. The address
  // mux is forced to zero when nothing is granted so that unknown addresses
  // on idle requesters never reach the ram.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && (grant_idx == PTR_W'(i));
    end
    ram_read_req  = grant_any;
    ram_read_addr = grant_any ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  end

  assign rsp_data = ram_read_data;

  // Lock / pointer bookkeeping. rsp_valid is the grant delayed by one cycle,
  // matching the ram's registered read data. A non-last beat locks the
  // grant to that requester; a last beat releases it and moves the
  // round-robin pointer just past the requester that finished.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= req_ready;
      if (grant_any) begin
        if (req_last[grant_idx]) begin
          state <= IDLE;
          ptr   <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end else begin
          state <= LOCKED;
          owner <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_rd_arbiter
//   Directed scenarios followed by random traffic, checked every cycle
//   against a rule-level model of the arbiter plus a behavioural ram with
//   one cycle of read latency.
// ---------------------------------------------------------------------------
module tb_ram_rd_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            ram_read_req;
  logic [AW-1:0]   ram_read_addr;
  logic [DW-1:0]   ram_read_data;

  logic [DW-1:0]   mem [0:(1<<AW)-1];

  // Reference state: lock flag, lock owner, round-robin start position,
  // and the response expected in the current cycle.
  bit              m_locked;
  int              m_owner;
  int              m_ptr;
  logic [N-1:0]    exp_rsp_valid;
  logic [DW-1:0]   exp_rsp_data;

  int              tests;
  int              fails;

  always #5 clk = ~clk;

  ram_rd_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .ram_read_req (ram_read_req),
    .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data)
  );

  // Behavioural ram with registered read data.
  always @(posedge clk) begin
    if (ram_read_req === 1'b1) ram_read_data <= mem[ram_read_addr];
  end

  // Which requester should be granted given the current request vector.
  function automatic int model_grant(input logic [N-1:0] v);
    if (m_locked) return (v[m_owner] === 1'b1) ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (v[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic logic [N*AW-1:0] pack(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic void model_reset();
    m_locked      = 1'b0;
    m_owner       = 0;
    m_ptr         = 0;
    exp_rsp_valid = '0;
  endfunction

  task automatic checkOutput(input string tag);
    int           g;
    logic [N-1:0] e_ready;
    logic [AW-1:0] e_addr;
    if (reset_n !== 1'b1) begin
      model_reset();
      g = -1;
    end else begin
      g = model_grant(req_valid);
    end
    e_ready = (g >= 0) ? (N'(1) << g) : '0;
    e_addr  = (g >= 0) ? req_addr[g*AW +: AW] : '0;

    tests++;
    assert (req_ready === e_ready) else begin
      fails++;
      $error("FAIL %s req_ready got %b expected %b", tag, req_ready, e_ready);
    end
    tests++;
    assert (ram_read_req === (g >= 0)) else begin
      fails++;
      $error("FAIL %s ram_read_req got %b expected %b", tag, ram_read_req, (g >= 0));
    end
    tests++;
    assert (ram_read_addr === e_addr) else begin
      fails++;
      $error("FAIL %s ram_read_addr got %h expected %h", tag, ram_read_addr, e_addr);
    end
    tests++;
    assert (rsp_valid === exp_rsp_valid) else begin
      fails++;
      $error("FAIL %s rsp_valid got %b expected %b", tag, rsp_valid, exp_rsp_valid);
    end
    if (exp_rsp_valid != '0) begin
      tests++;
      assert (rsp_data === exp_rsp_data) else begin
        fails++;
        $error("FAIL %s rsp_data got %h expected %h", tag, rsp_data, exp_rsp_data);
      end
    end

    // Advance the model to what the next clock edge should produce.
    if (reset_n === 1'b1) begin
      exp_rsp_valid = e_ready;
      if (g >= 0) begin
        exp_rsp_data = mem[e_addr];
        if (req_last[g]) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic [N-1:0] v, input logic [N-1:0] l,
                               input logic [N*AW-1:0] a, input string tag);
    @(negedge clk);
    reset_n   = rn;
    req_valid = v;
    req_last  = l;
    req_addr  = a;
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [N-1:0]    rv;
    logic [N-1:0]    rl;
    logic [N*AW-1:0] ra;

    tests = 0;
    fails = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom_range(0, 255));
    mem[5] = 8'h11;
    mem[6] = 8'h22;
    mem[7] = 8'h33;
    model_reset();
    exp_rsp_data = '0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;

    // Reset held with every requester asking, then release: req0 first.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1111, 4'b1111, pack(12'h100, 12'h101, 12'h102, 12'h103), "reset");
    applyStimulus(1'b1, 4'b1111, 4'b1111, pack(12'h100, 12'h101, 12'h102, 12'h103), "release");

    // Single requester streaming three reads back-to-back.
    applyStimulus(1'b1, 4'b0001, 4'b1111, pack(12'd5, 12'hxxx, 12'hxxx, 12'hxxx), "single_5");
    applyStimulus(1'b1, 4'b0001, 4'b1111, pack(12'd6, 12'hxxx, 12'hxxx, 12'hxxx), "single_6");
    applyStimulus(1'b1, 4'b0001, 4'b1111, pack(12'd7, 12'hxxx, 12'hxxx, 12'hxxx), "single_7");
    applyStimulus(1'b1, 4'b0000, 4'b1111, pack(12'hxxx, 12'hxxx, 12'hxxx, 12'hxxx), "single_idle");

    // Two requesters contending with single reads.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 4'b0011, 4'b1111, pack(AW'(16 + i), AW'(32 + i), 12'h0, 12'h0), "contend");

    // Four-beat burst on req1 while req0 and req2 also ask.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 4'b0111, 4'b1101, pack(12'h200, AW'(12'h300 + i), 12'h400, 12'h0), "burst");
    applyStimulus(1'b1, 4'b0111, 4'b1111, pack(12'h200, 12'h303, 12'h400, 12'h0), "burst_last");
    applyStimulus(1'b1, 4'b0101, 4'b1111, pack(12'h201, 12'h0, 12'h401, 12'h0), "after_burst");
    applyStimulus(1'b1, 4'b0101, 4'b1111, pack(12'h202, 12'h0, 12'h402, 12'h0), "after_burst");
    applyStimulus(1'b1, 4'b0000, 4'b1111, pack(12'h0, 12'h0, 12'h0, 12'h0), "gap");

    // Owner req2 drops valid mid-burst while req0 asks: bubbles, lock held.
    applyStimulus(1'b1, 4'b0100, 4'b1011, pack(12'hxxx, 12'hxxx, 12'h500, 12'hxxx), "lock_start");
    applyStimulus(1'b1, 4'b0001, 4'b1011, pack(12'h0aa, 12'hxxx, 12'hxxx, 12'hxxx), "bubble");
    applyStimulus(1'b1, 4'b0001, 4'b1011, pack(12'h0ab, 12'hxxx, 12'hxxx, 12'hxxx), "bubble");
    applyStimulus(1'b1, 4'b0101, 4'b1011, pack(12'h0ac, 12'hxxx, 12'h501, 12'hxxx), "resume");
    applyStimulus(1'b1, 4'b0101, 4'b1111, pack(12'h0ad, 12'hxxx, 12'h502, 12'hxxx), "resume_last");
    applyStimulus(1'b1, 4'b0001, 4'b1111, pack(12'h0ae, 12'hxxx, 12'hxxx, 12'hxxx), "post_lock");

    // Asynchronous reset between clock edges in the middle of a burst.
    applyStimulus(1'b1, 4'b0010, 4'b1101, pack(12'h0, 12'h600, 12'h0, 12'h0), "pre_reset");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    assert (rsp_valid === 4'b0000) else begin
      fails++;
      $error("FAIL async_reset rsp_valid got %b expected %b", rsp_valid, 4'b0000);
    end
    tests++;
    assert (ram_read_req === 1'b0) else begin
      fails++;
      $error("FAIL async_reset ram_read_req got %b expected %b", ram_read_req, 1'b0);
    end
    model_reset();
    applyStimulus(1'b0, 4'b1111, 4'b1101, pack(12'h10, 12'h601, 12'h30, 12'h40), "in_reset");
    applyStimulus(1'b1, 4'b1111, 4'b1111, pack(12'h11, 12'h602, 12'h31, 12'h41), "post_reset");
    applyStimulus(1'b1, 4'b1110, 4'b1111, pack(12'h12, 12'h603, 12'h32, 12'h42), "post_reset");
    applyStimulus(1'b1, 4'b0000, 4'b1111, pack(12'h0, 12'h0, 12'h0, 12'h0), "post_reset");

    // Random traffic: random request/last patterns, unknown addresses on
    // some requesters that are not asking.
    for (int c = 0; c < 400; c++) begin
      rv = N'($urandom_range(0, 15));
      rl = N'($urandom_range(0, 15)) | N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && ($urandom_range(0, 3) == 0)) ra[i*AW +: AW] = 'x;
        else ra[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
      end
      applyStimulus(1'b1, rv, rl, ra, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
